// File: rtl/noc_ni_pkg.sv
// Shared constants for the NoC network interface: CPU register offsets,
// STATUS bit positions and the flit field layout.
package noc_ni_pkg;

    localparam logic [2:0] OFF_TX_DEST = 3'd0;
    localparam logic [2:0] OFF_TX_DATA = 3'd1;
    localparam logic [2:0] OFF_RX_DATA = 3'd2;
    localparam logic [2:0] OFF_RX_SRC  = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;
    localparam logic [2:0] OFF_IRQ_EN  = 3'd5;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_UNF     = 5;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_RX_CNT_W   = 8;

    // A flit is {dest_or_src, payload}: the address field sits above the payload.
    localparam int FLIT_PAYLOAD_LSB = 0;

    function automatic int flit_width(int dest_w, int data_w);
        return dest_w + data_w;
    endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module ni_sync_fifo
    import noc_ni_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/noc_network_interface.sv
// CPU-mapped network interface: TX FIFO feeding the NoC, RX FIFO draining it,
// sticky error flags and a registered level interrupt.
module noc_network_interface
    import noc_ni_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEST_W    = 32,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int RX_THRESH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [DEST_W+DATA_W-1:0] tx_flit,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [DEST_W+DATA_W-1:0] rx_flit,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     irq
);

    localparam int FLIT_W = flit_width(DEST_W, DATA_W);
    localparam int TX_CW  = $clog2(TX_DEPTH+1);
    localparam int RX_CW  = $clog2(RX_DEPTH+1);

    logic [2:0]        offset;
    logic [DEST_W-1:0] tx_dest_q, tx_dest_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic              tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] status;

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_rd, rx_full, rx_empty;
    logic [TX_CW-1:0]  tx_count;
    logic [RX_CW-1:0]  rx_count;
    logic [FLIT_W-1:0] rx_head;
    logic              unused_addr_bits;

    assign offset           = cpu_addr[4:2];
    assign unused_addr_bits = ^{cpu_addr[31:5], cpu_addr[1:0], tx_count};

    // Both NoC ports: a flit moves on a cycle where valid and ready are both 1;
    // the sender holds the flit stable while valid=1 and ready=0.
    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign tx_push  = cpu_we & (offset == OFF_TX_DATA);
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_rd    = cpu_re & (offset == OFF_RX_DATA);
    assign rx_pop   = rx_rd & ~rx_empty;

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i ({tx_dest_q, cpu_wdata}),
        .rdata_o (tx_flit),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (rx_flit),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status                               = '0;
        status[ST_TX_FULL]                   = tx_full;
        status[ST_TX_EMPTY]                  = tx_empty;
        status[ST_RX_FULL]                   = rx_full;
        status[ST_RX_EMPTY]                  = rx_empty;
        status[ST_TX_OVF]                    = tx_ovf_q;
        status[ST_RX_UNF]                    = rx_unf_q;
        status[ST_RX_CNT_LSB +: ST_RX_CNT_W] = ST_RX_CNT_W'(rx_count);
    end

    always_comb begin
        tx_dest_d = tx_dest_q;
        irq_en_d  = irq_en_q;
        if (cpu_we && offset == OFF_TX_DEST) tx_dest_d = DEST_W'(cpu_wdata);
        if (cpu_we && offset == OFF_IRQ_EN)  irq_en_d  = cpu_wdata[1:0];

        // A set event in the same cycle as a W1C clear keeps the flag set.
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (cpu_we && offset == OFF_STATUS && cpu_wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
        if (cpu_we && offset == OFF_STATUS && cpu_wdata[ST_RX_UNF]) rx_unf_d = 1'b0;
        if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        if (rx_rd && rx_empty)             rx_unf_d = 1'b1;

        rdata_d = rdata_q;
        if (cpu_re) begin
            case (offset)
                OFF_TX_DEST: rdata_d = DATA_W'(tx_dest_q);
                OFF_RX_DATA: rdata_d = rx_empty ? '0 : rx_head[FLIT_PAYLOAD_LSB +: DATA_W];
                OFF_RX_SRC:  rdata_d = rx_empty ? '0 : DATA_W'(rx_head[FLIT_W-1 -: DEST_W]);
                OFF_STATUS:  rdata_d = status;
                OFF_IRQ_EN:  rdata_d = DATA_W'(irq_en_q);
                default:     rdata_d = '0;
            endcase
        end

        irq_d = (irq_en_q[0] & (32'(rx_count) >= RX_THRESH)) |
                (irq_en_q[1] & tx_empty) | tx_ovf_q | rx_unf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_dest_q <= '0;
            irq_en_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            tx_dest_q <= tx_dest_d;
            irq_en_q  <= irq_en_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_noc_network_interface.sv
// Self-checking bench for noc_network_interface: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_noc_network_interface;

    localparam int DATA_W = 32;
    localparam int DEST_W = 32;
    localparam int FLIT_W = DEST_W + DATA_W;
    localparam int TXD    = 8;
    localparam int RXD    = 8;
    localparam int THRESH = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we, cpu_re;
    logic [DATA_W-1:0] cpu_rdata;
    logic [FLIT_W-1:0] tx_flit;
    logic              tx_valid, tx_ready;
    logic [FLIT_W-1:0] rx_flit;
    logic              rx_valid, rx_ready;
    logic              irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [FLIT_W-1:0] tx_q[$];
    logic [FLIT_W-1:0] rx_q[$];
    logic [DEST_W-1:0] m_dest;
    logic [1:0]        m_irqen;
    logic              m_ovf, m_unf, m_irq;
    logic [DATA_W-1:0] m_rdata;

    always #5 clk = ~clk;

    noc_network_interface #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_THRESH(THRESH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .tx_flit   (tx_flit),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_flit   (rx_flit),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .irq       (irq)
    );

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int          tn = tx_q.size();
        int          rn = rx_q.size();
        logic [2:0]  off = cpu_addr[4:2];
        logic        tpop = (tn > 0) && tx_ready;
        logic        tpush = cpu_we && off == 3'd1;
        logic        tacc = tpush && (tn < TXD || tpop);
        logic        rpush = rx_valid && (rn < RXD);
        logic        rrd = cpu_re && off == 3'd2;
        logic        rpop = rrd && (rn > 0);
        logic        irq_next;
        logic [DATA_W-1:0] status;
        if (reset) begin
            tx_q.delete();
            rx_q.delete();
            m_dest = '0; m_irqen = '0; m_ovf = 0; m_unf = 0; m_irq = 0; m_rdata = '0;
            return;
        end
        irq_next = (m_irqen[0] && rn >= THRESH) || (m_irqen[1] && tn == 0) || m_ovf || m_unf;
        status = {16'h0, 8'(rn), 2'b00, m_unf, m_ovf, rn == 0, rn == RXD, tn == 0, tn == TXD};
        if (cpu_re) begin
            case (off)
                3'd0:    m_rdata = m_dest;
                3'd2:    m_rdata = (rn > 0) ? rx_q[0][DATA_W-1:0] : '0;
                3'd3:    m_rdata = (rn > 0) ? rx_q[0][FLIT_W-1:DATA_W] : '0;
                3'd4:    m_rdata = status;
                3'd5:    m_rdata = {30'h0, m_irqen};
                default: m_rdata = '0;
            endcase
        end
        if (cpu_we && off == 3'd4 && cpu_wdata[4]) m_ovf = 0;
        if (cpu_we && off == 3'd4 && cpu_wdata[5]) m_unf = 0;
        if (tpush && !tacc) m_ovf = 1;
        if (rrd && rn == 0) m_unf = 1;
        if (tpop) void'(tx_q.pop_front());
        if (tacc) tx_q.push_back({m_dest, cpu_wdata});
        if (rpop) void'(rx_q.pop_front());
        if (rpush) rx_q.push_back(rx_flit);
        if (cpu_we && off == 3'd0) m_dest = cpu_wdata;
        if (cpu_we && off == 3'd5) m_irqen = cpu_wdata[1:0];
        m_irq = irq_next;
    endtask

    // Apply inputs for one cycle, clock once, update the model, settle #1.
    task automatic step(input logic rst, input logic we, input logic re, input logic [2:0] off,
                        input logic [31:0] wd, input logic txr, input logic rxv,
                        input logic [FLIT_W-1:0] rxf);
        reset = rst; cpu_we = we; cpu_re = re; cpu_addr = {27'h0, off, 2'b00};
        cpu_wdata = wd; tx_ready = txr; rx_valid = rxv; rx_flit = rxf;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic txr);
        step(0, 0, 0, 3'd0, 32'h0, txr, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 3'd0, 32'h0, 0, 0, '0);
        step(1, 0, 0, 3'd0, 32'h0, 0, 0, '0);
        idle(0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %0b want 1", rx_ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'h0000000A) begin errors++; $display("FAIL reset_status got %h want 0000000a", cpu_rdata); end
    endtask

    task automatic test_tx_order();
        do_reset();
        step(0, 1, 0, 3'd0, 32'h5, 0, 0, '0);
        step(0, 1, 0, 3'd1, 32'hA1, 0, 0, '0);
        step(0, 1, 0, 3'd1, 32'hA2, 0, 0, '0);
        checks++; if (tx_valid !== 1'b1 || tx_flit !== {32'h5, 32'hA1})
            begin errors++; $display("FAIL tx_order_first got v=%0b %h want 1 %h", tx_valid, tx_flit, {32'h5, 32'hA1}); end
        idle(1);
        checks++; if (tx_valid !== 1'b1 || tx_flit !== {32'h5, 32'hA2})
            begin errors++; $display("FAIL tx_order_second got v=%0b %h want 1 %h", tx_valid, tx_flit, {32'h5, 32'hA2}); end
        idle(1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_order_drain got %0b want 0", tx_valid); end
    endtask

    task automatic test_tx_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 1, 0, 3'd1, 32'h100 + i, 0, 0, '0);
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if ((cpu_rdata & 32'h13) !== 32'h11)
            begin errors++; $display("FAIL tx_ovf_status got %h want bits0,4 set bit1 clear", cpu_rdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_ovf_irq got %0b want 1", irq); end
        checks++; if (tx_flit !== {32'h0, 32'h100}) begin errors++; $display("FAIL tx_ovf_head got %h want %h", tx_flit, {32'h0, 32'h100}); end
        step(0, 1, 0, 3'd4, 32'h10, 0, 0, '0);
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata[4] !== 1'b0) begin errors++; $display("FAIL tx_ovf_w1c got %0b want 0", cpu_rdata[4]); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_ovf_irq_clear got %0b want 0", irq); end
        // Drain: the ninth write must not have been stored.
        for (int i = 0; i < 8; i++) idle(1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ovf_dropped got %0b want 0", tx_valid); end
    endtask

    task automatic test_rx_src_data();
        do_reset();
        step(0, 0, 0, 3'd0, 32'h0, 0, 1, {32'h3, 32'h77});
        step(0, 0, 1, 3'd3, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'h3) begin errors++; $display("FAIL rx_src got %h want 3", cpu_rdata); end
        step(0, 0, 1, 3'd2, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'h77) begin errors++; $display("FAIL rx_data got %h want 77", cpu_rdata); end
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata[3] !== 1'b1) begin errors++; $display("FAIL rx_empty_after got %0b want 1", cpu_rdata[3]); end
    endtask

    task automatic test_rx_underflow();
        do_reset();
        step(0, 1, 0, 3'd0, 32'hDEAD, 0, 0, '0);
        step(0, 0, 1, 3'd0, 32'h0, 0, 0, '0);
        step(0, 0, 1, 3'd2, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rx_unf_data got %h want 0", cpu_rdata); end
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata[5] !== 1'b1) begin errors++; $display("FAIL rx_unf_flag got %0b want 1", cpu_rdata[5]); end
    endtask

    task automatic test_rx_irq();
        do_reset();
        step(0, 1, 0, 3'd5, 32'h1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3'd0, 32'h0, 0, 1, {32'(i), 32'(i + 10)});
        idle(0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_below got %0b want 0", irq); end
        step(0, 0, 0, 3'd0, 32'h0, 0, 1, {32'h9, 32'h99});
        idle(0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_rise got %0b want 1", irq); end
        step(0, 0, 1, 3'd2, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'd10) begin errors++; $display("FAIL rx_irq_pop got %h want a", cpu_rdata); end
        idle(0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_fall got %0b want 0", irq); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 3'd1, 32'h200 + i, 0, 0, '0);
        step(0, 1, 0, 3'd1, 32'h2FF, 1, 0, '0);
        checks++; if (tx_flit !== {32'h0, 32'h201}) begin errors++; $display("FAIL full_pp_head got %h want %h", tx_flit, {32'h0, 32'h201}); end
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if ((cpu_rdata & 32'h13) !== 32'h01)
            begin errors++; $display("FAIL full_pp_status got %h want full, no overflow", cpu_rdata); end
        for (int i = 0; i < 7; i++) idle(1);
        checks++; if (tx_flit !== {32'h0, 32'h2FF}) begin errors++; $display("FAIL full_pp_last got %h want %h", tx_flit, {32'h0, 32'h2FF}); end
        // Reset in the middle of a streaming burst
        step(0, 1, 0, 3'd1, 32'h300, 1, 1, {32'h1, 32'h1});
        step(0, 1, 0, 3'd1, 32'h301, 0, 1, {32'h2, 32'h2});
        step(1, 1, 0, 3'd1, 32'h302, 1, 1, {32'h3, 32'h3});
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid got %0b want 0", tx_valid); end
        step(0, 0, 1, 3'd4, 32'h0, 0, 0, '0);
        checks++; if (cpu_rdata !== 32'h0000000A) begin errors++; $display("FAIL midreset_status got %h want 0000000a", cpu_rdata); end
    endtask

    task automatic test_random();
        logic [2:0] off;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            off = 3'($urandom_range(0, 7));
            if (off == 3'd2 || off == 3'd3) off = ($urandom_range(0, 1) != 0) ? off : 3'd1;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, off,
                 $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 {32'($urandom), 32'($urandom)});
            checks++; if (tx_valid !== (tx_q.size() != 0))
                begin errors++; $display("FAIL rand_tx_valid cyc %0d got %0b want %0b", n, tx_valid, tx_q.size() != 0); end
            if (tx_q.size() != 0) begin
                checks++; if (tx_flit !== tx_q[0])
                    begin errors++; $display("FAIL rand_tx_flit cyc %0d got %h want %h", n, tx_flit, tx_q[0]); end
            end
            checks++; if (rx_ready !== (rx_q.size() < RXD))
                begin errors++; $display("FAIL rand_rx_ready cyc %0d got %0b want %0b", n, rx_ready, rx_q.size() < RXD); end
            checks++; if (cpu_rdata !== m_rdata)
                begin errors++; $display("FAIL rand_rdata cyc %0d got %h want %h", n, cpu_rdata, m_rdata); end
            checks++; if (irq !== m_irq)
                begin errors++; $display("FAIL rand_irq cyc %0d got %0b want %0b", n, irq, m_irq); end
        end
    endtask

    initial begin
        reset = 1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0; cpu_re = 0;
        tx_ready = 0; rx_valid = 0; rx_flit = '0;
        m_dest = '0; m_irqen = '0; m_ovf = 0; m_unf = 0; m_irq = 0; m_rdata = '0;
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_rx_src_data();
        test_rx_underflow();
        test_rx_irq();
        test_full_push_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
